uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//  Oversampling UART receiver, the serial counterpart of the UART transmitter. It deserialises
//  frames of the form start(0), DATA_WIDTH data bits LSB-first, optional parity, stop(1).
//  Idle line is high. Delivers a parallel word with a 1-cycle valid strobe, or a parity/stop
//  error strobe. Sits between the synchronised RX pin and the register/FIFO side of the UART.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame; must match the peer transmitter.
// PORTS
//  CLK         in   1           oversampling clock; all logic on rising edge.
//  RST         in   1           synchronous, active-high reset.
//  RX_IN       in   1           serial line, already synchronised to CLK.
//  PRESCALE    in   6           CLK cycles per bit; legal 8/16/32; any other value is treated as 8.
//  PAR_EN      in   1           1 = frame carries a parity bit.
//  PAR_TYP     in   1           0 = even, 1 = odd parity.
//  P_DATA      out  DATA_WIDTH  last good word; holds until next good frame.
//  Data_Valid  out  1           1-cycle pulse, P_DATA updated this cycle.
//  Par_Err     out  1           1-cycle pulse, parity mismatch.
//  Stp_Err     out  1           1-cycle pulse, stop bit sampled 0.
//  Busy        out  1           high from start detect through stop-bit decision.
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, counters 0, armed=0. Reset mid-frame drops the partial
//    frame with no strobe.
//  - armed flag: set when RX_IN=1 is seen in IDLE. Start detection requires armed=1, so a
//    line held low out of reset or after a break never creates a frame.
//  - FSM: IDLE -> START -> DATA -> [PARITY if PAR_EN] -> STOP -> IDLE.
//  - PRESCALE, PAR_EN and PAR_TYP are latched in the start-detect cycle. Later changes are
//    ignored until the next frame.
//  - IDLE: when armed and RX_IN=0, go to START. The detect cycle is edge_cnt=0 of the start bit.
//  - edge_cnt runs 0..PRESCALE-1 per bit and wraps to 0 at the bit boundary. bit_cnt counts
//    data bits 0..DATA_WIDTH-1.
//  - Sample point: edge_cnt == PRESCALE/2 (decision edge; see CONFIGURATION).
//  - START: if the sampled start bit is 1, treat it as a glitch. Return to IDLE on the next
//    cycle, Busy=0, no strobe.
//  - DATA: shift the sampled bit into bit_cnt position (LSB first). After DATA_WIDTH bits go
//    to PARITY or STOP.
//  - PARITY: expected = ^data ^ PAR_TYP. Record a mismatch flag.
//  - STOP: at the decision edge, go to IDLE on the next cycle. This half-bit resync allows
//    back-to-back frames with no idle gap. Exactly one of three outcomes is registered for
//    the following cycle:
//      * stop=1 and parity ok: P_DATA <= word, Data_Valid=1.
//      * stop=1 and parity bad: Par_Err=1, P_DATA unchanged.
//      * stop=0: Stp_Err=1 (Par_Err also 1 if parity is bad), P_DATA unchanged, armed <= 0.
//  - Latency, macro off: T0 = start-detect cycle, N = 1 + DATA_WIDTH + PAR_EN.
//    The strobe occurs at T0 + N*PRESCALE + PRESCALE/2 + 1.
//  - Busy falls in the same cycle the strobe rises.
// CONFIGURATION
//  UART_RX_MAJORITY_EN
//  - Defined: every bit (start included) takes 3 samples at edge_cnt PRESCALE/2-1, PRESCALE/2
//    and PRESCALE/2+1. The value is the 2-of-3 majority. The decision edge is PRESCALE/2+1,
//    so all strobes move 1 cycle later.
//  - Undefined: single sample at PRESCALE/2; the decision edge is PRESCALE/2.
// TESTING (DATA_WIDTH=8)
//  1. RST=1 for 2 cycles, RX_IN=1 -> all outputs 0, Busy=0. Then RST mid-frame -> no strobe,
//     Busy=0 on the next cycle.
//  2. PRESCALE=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity 0 -> Data_Valid 1 cycle at
//     T0+85, P_DATA=0xA5, Par_Err=Stp_Err=0.
//  3. PAR_TYP=1, frame 0x3C with parity bit 0 -> Par_Err pulse, Data_Valid=0, P_DATA stays 0xA5.
//  4. Frame 0x55 with stop=0, then RX_IN held low 100 cycles -> one Stp_Err pulse, Busy=0.
//     No further frame until RX_IN returns high and a new start follows.
//  5. PRESCALE=16, RX_IN low for 2 cycles only -> Busy=1 then 0 at T0+9, no strobes.
//  6. PRESCALE=32, PAR_EN=0, back-to-back 0x01 then 0xFF with no gap -> two Data_Valid pulses
//     320 cycles apart. With UART_RX_MAJORITY_EN, a 1-cycle inversion at PRESCALE/2 of bit 3
//     still yields 0xFF; without the macro, P_DATA=0xF7.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver for start / DATA_WIDTH data bits (LSB first) / optional parity / stop frames.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority sampling around mid-bit, decision one edge later.
module uart_rx_core #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rx_in_i,
    input  logic [5:0]            prescale_i,
    input  logic                  par_en_i,
    input  logic                  par_typ_i,
    output logic [DATA_WIDTH-1:0] p_data_o,
    output logic                  data_valid_o,
    output logic                  par_err_o,
    output logic                  stp_err_o,
    output logic                  busy_o
);

    localparam int unsigned       CNT_W      = 6;
    localparam int unsigned       BIT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0]  PRESC_DFLT = CNT_W'(8);
    localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        edge_q;
    logic [CNT_W-1:0]        presc_q;
    logic [BIT_W-1:0]        bit_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [DATA_WIDTH-1:0]   p_data_q;
    logic                    par_en_q;
    logic                    par_typ_q;
    logic                    par_bad_q;
    logic                    armed_q;
    logic                    data_valid_q;
    logic                    par_err_q;
    logic                    stp_err_q;
    logic                    busy_q;

    logic [CNT_W-1:0]        presc_sel;
    logic [CNT_W-1:0]        half;
    logic [CNT_W-1:0]        dec_edge;
    logic                    at_dec;
    logic                    at_wrap;
    logic                    bit_val;
    logic                    par_exp;

    // Unsupported prescale values fall back to 8 cycles per bit
    always_comb begin
        presc_sel = PRESC_DFLT;
        if (prescale_i == CNT_W'(16) || prescale_i == CNT_W'(32)) begin
            presc_sel = prescale_i;
        end
    end

    assign half    = presc_q >> 1;
    assign at_wrap = (edge_q == presc_q - CNT_W'(1));
    assign at_dec  = (edge_q == dec_edge);
    assign par_exp = (^shift_q) ^ par_typ_q;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] smp_q;

    // Third vote is the live line value at the decision edge
    assign dec_edge = half + CNT_W'(1);
    assign bit_val  = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_in_i) | (smp_q[1] & rx_in_i);
`else
    assign dec_edge = half;
    assign bit_val  = rx_in_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            edge_q       <= '0;
            presc_q      <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            p_data_q     <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            armed_q      <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            smp_q        <= '0;
`endif
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;

            if (state_q != S_IDLE) begin
                edge_q <= at_wrap ? '0 : edge_q + CNT_W'(1);
            end
`ifdef UART_RX_MAJORITY_EN
            if (edge_q == half - CNT_W'(1)) smp_q[0] <= rx_in_i;
            if (edge_q == half)             smp_q[1] <= rx_in_i;
`endif

            case (state_q)
                S_IDLE: begin
                    edge_q <= '0;
                    bit_q  <= '0;
                    // A line never seen high (reset, break) must not start a frame
                    if (!armed_q) begin
                        if (rx_in_i) armed_q <= 1'b1;
                    end else if (!rx_in_i) begin
                        state_q   <= S_START;
                        busy_q    <= 1'b1;
                        edge_q    <= CNT_W'(1);
                        presc_q   <= presc_sel;
                        par_en_q  <= par_en_i;
                        par_typ_q <= par_typ_i;
                        par_bad_q <= 1'b0;
                    end
                end

                S_START: begin
                    if (at_dec && bit_val) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (at_wrap) begin
                        state_q <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (at_dec) shift_q[bit_q] <= bit_val;
                    if (at_wrap) begin
                        if (bit_q == LAST_BIT) begin
                            bit_q   <= '0;
                            state_q <= par_en_q ? S_PARITY : S_STOP;
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end
                end

                S_PARITY: begin
                    if (at_dec)  par_bad_q <= bit_val ^ par_exp;
                    if (at_wrap) state_q   <= S_STOP;
                end

                S_STOP: begin
                    // Leave at mid-stop so a following start edge is caught with no idle gap
                    if (at_dec) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        edge_q  <= '0;
                        if (bit_val) begin
                            if (par_bad_q) begin
                                par_err_q <= 1'b1;
                            end else begin
                                data_valid_q <= 1'b1;
                                p_data_q     <= shift_q;
                            end
                        end else begin
                            stp_err_q <= 1'b1;
                            par_err_q <= par_bad_q;
                            armed_q   <= 1'b0;
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign p_data_o     = p_data_q;
    assign data_valid_o = data_valid_q;
    assign par_err_o    = par_err_q;
    assign stp_err_o    = stp_err_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed and randomized frames against a frame-level timing/outcome model.
`timescale 1ns/1ps
module tb_uart_rx_core;

    localparam int DW   = 8;
    localparam int MAXC = 40000;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    typedef struct packed {
        logic [31:0] cyc;
        logic        dv;
        logic        pe;
        logic        se;
        logic [7:0]  data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [5:0] presc;
    logic       pen;
    logic       ptyp;
    logic [7:0] pdata;
    logic       dv, pe, se, busy;

    int   ncyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    ev_t  got_q[$];
    ev_t  exp_q[$];
    bit   wave[$];
    logic busy_hist [MAXC];
    logic [7:0] exp_pdata;

    always #5 clk = ~clk;

    uart_rx_core #(.DATA_WIDTH(DW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rx_in_i      (rx),
        .prescale_i   (presc),
        .par_en_i     (pen),
        .par_typ_i    (ptyp),
        .p_data_o     (pdata),
        .data_valid_o (dv),
        .par_err_o    (pe),
        .stp_err_o    (se),
        .busy_o       (busy)
    );

    always @(posedge clk) ncyc <= ncyc + 1;

    // Record every strobe and the busy history, labelled by cycle index
    always @(negedge clk) begin
        if (ncyc < MAXC) busy_hist[ncyc] = busy;
        if (dv === 1'b1 || pe === 1'b1 || se === 1'b1)
            got_q.push_back('{32'(ncyc), dv, pe, se, pdata});
    end

    function automatic string ev_str(ev_t e);
        return $sformatf("cyc=%0d dv=%b pe=%b se=%b data=%h", e.cyc, e.dv, e.pe, e.se, e.data);
    endfunction

    function automatic int add_frame(logic [7:0] d, int p, bit pen_b, bit pbit, bit stop);
        int off = wave.size();
        repeat (p) wave.push_back(1'b0);
        for (int b = 0; b < DW; b++) repeat (p) wave.push_back(d[b]);
        if (pen_b) repeat (p) wave.push_back(pbit);
        repeat (p) wave.push_back(stop);
        return off;
    endfunction

    // Frame-level reference: outcome from parity/stop rules, timing from bit count
    function automatic void model(int t0, logic [7:0] d, int p, bit pen_b, bit ptyp_b, bit pbit, bit stop);
        int  peff  = (p == 8 || p == 16 || p == 32) ? p : 8;
        int  nbits = 1 + DW + (pen_b ? 1 : 0);
        bit  want  = ((($countones(d) % 2) == 1) ? 1'b1 : 1'b0) ^ ptyp_b;
        bit  bad   = pen_b && (pbit != want);
        ev_t e;
        e.cyc = 32'(t0 + nbits * peff + peff / 2 + 1 + MAJ);
        e.dv  = stop && !bad;
        e.pe  = bad;
        e.se  = !stop;
        if (e.dv) exp_pdata = d;
        e.data = exp_pdata;
        exp_q.push_back(e);
    endfunction

    function automatic bit good_par(logic [7:0] d, bit ptyp_b);
        return ((($countones(d) % 2) == 1) ? 1'b1 : 1'b0) ^ ptyp_b;
    endfunction

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    task automatic play(output int base, input int scr);
        base = -1;
        foreach (wave[i]) begin
            @(negedge clk);
            rx = wave[i];
            if (i == 0) base = ncyc;
            if (i == scr) begin
                presc = 6'($urandom_range(0, 63));
                pen   = 1'($urandom_range(0, 1));
                ptyp  = 1'($urandom_range(0, 1));
            end
        end
        wave.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; presc = 6'd8; pen = 1'b0; ptyp = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({dv, pe, se, busy} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: dv/pe/se/busy=%b%b%b%b, expected 0000", dv, pe, se, busy);
        end
        vectors++;
        if (pdata !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_pdata: got %h, expected 00", pdata);
        end
        rst = 1'b0;
        idle(4);
        got_q.delete();
        repeat (8) begin @(negedge clk); rx = 1'b0; end
        repeat (8) begin @(negedge clk); rx = 1'b1; end
        repeat (5) begin @(negedge clk); rx = 1'b0; end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_busy_mid: got %b, expected 1", busy);
        end
        rst = 1'b1; rx = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy_after: got %b, expected 0", busy);
        end
        rst = 1'b0;
        idle(200);
        vectors++;
        if (got_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_no_strobe: %0d strobes seen, expected 0", got_q.size());
        end
        exp_pdata = 8'h00;
    endtask

    task automatic test_good_frame();
        int base, off, t0, s;
        got_q.delete(); exp_q.delete();
        presc = 6'd8; pen = 1'b1; ptyp = 1'b0;
        off = add_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1);
        repeat (20) wave.push_back(1'b1);
        play(base, -1);
        t0 = base + off;
        model(t0, 8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL good_count: %0d strobes seen, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL good_strobe[%0d]: got %s, expected %s", i, ev_str(got_q[i]), ev_str(exp_q[i]));
            end
        end
        s = int'(exp_q[0].cyc);
        vectors++;
        if ({busy_hist[t0], busy_hist[t0+1], busy_hist[s-1], busy_hist[s]} !== 4'b0110) begin
            miscompares++;
            $display("FAIL good_busy: busy at t0,t0+1,strobe-1,strobe=%b%b%b%b, expected 0110",
                     busy_hist[t0], busy_hist[t0+1], busy_hist[s-1], busy_hist[s]);
        end
    endtask

    task automatic test_parity_error();
        int base, off;
        got_q.delete(); exp_q.delete();
        presc = 6'd8; pen = 1'b1; ptyp = 1'b1;
        off = add_frame(8'h3C, 8, 1'b1, 1'b0, 1'b1);
        repeat (20) wave.push_back(1'b1);
        play(base, -1);
        model(base + off, 8'h3C, 8, 1'b1, 1'b1, 1'b0, 1'b1);
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL parity_count: %0d strobes seen, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL parity_strobe[%0d]: got %s, expected %s", i, ev_str(got_q[i]), ev_str(exp_q[i]));
            end
        end
        vectors++;
        if (pdata !== exp_pdata) begin
            miscompares++;
            $display("FAIL parity_hold: p_data %h, expected %h", pdata, exp_pdata);
        end
    endtask

    task automatic test_stop_error();
        int base, off1, off2;
        got_q.delete(); exp_q.delete();
        presc = 6'd8; pen = 1'b1; ptyp = 1'b1;
        off1 = add_frame(8'h55, 8, 1'b1, good_par(8'h55, 1'b1), 1'b0);
        repeat (100) wave.push_back(1'b0);
        repeat (5) wave.push_back(1'b1);
        off2 = add_frame(8'h81, 8, 1'b1, good_par(8'h81, 1'b1), 1'b1);
        repeat (20) wave.push_back(1'b1);
        play(base, -1);
        model(base + off1, 8'h55, 8, 1'b1, 1'b1, good_par(8'h55, 1'b1), 1'b0);
        model(base + off2, 8'h81, 8, 1'b1, 1'b1, good_par(8'h81, 1'b1), 1'b1);
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL stop_count: %0d strobes seen, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL stop_strobe[%0d]: got %s, expected %s", i, ev_str(got_q[i]), ev_str(exp_q[i]));
            end
        end
        vectors++;
        if (busy_hist[base + off2 - 1] !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_busy_break: got %b, expected 0", busy_hist[base + off2 - 1]);
        end
    endtask

    task automatic test_glitch();
        int base;
        got_q.delete();
        presc = 6'd16; pen = 1'b0; ptyp = 1'b0;
        wave.push_back(1'b0);
        wave.push_back(1'b0);
        repeat (40) wave.push_back(1'b1);
        play(base, -1);
        vectors++;
        if (got_q.size() != 0) begin
            miscompares++;
            $display("FAIL glitch_no_strobe: %0d strobes seen, expected 0", got_q.size());
        end
        vectors++;
        if ({busy_hist[base+1], busy_hist[base+8+MAJ], busy_hist[base+9+MAJ]} !== 3'b110) begin
            miscompares++;
            $display("FAIL glitch_busy: busy at t0+1,t0+%0d,t0+%0d=%b%b%b, expected 110", 8 + MAJ, 9 + MAJ,
                     busy_hist[base+1], busy_hist[base+8+MAJ], busy_hist[base+9+MAJ]);
        end
    endtask

    task automatic test_back_to_back();
        int base, off1, off2;
        logic [7:0] sampled;
        got_q.delete(); exp_q.delete();
        presc = 6'd32; pen = 1'b0; ptyp = 1'b0;
        off1 = add_frame(8'h01, 32, 1'b0, 1'b0, 1'b1);
        off2 = add_frame(8'hFF, 32, 1'b0, 1'b0, 1'b1);
        repeat (40) wave.push_back(1'b1);
        play(base, -1);
        model(base + off1, 8'h01, 32, 1'b0, 1'b0, 1'b0, 1'b1);
        model(base + off2, 8'hFF, 32, 1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL b2b_count: %0d strobes seen, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL b2b_strobe[%0d]: got %s, expected %s", i, ev_str(got_q[i]), ev_str(exp_q[i]));
            end
        end
        if (got_q.size() == 2) begin
            vectors++;
            if (int'(got_q[1].cyc) - int'(got_q[0].cyc) != 320) begin
                miscompares++;
                $display("FAIL b2b_spacing: got %0d cycles, expected 320", int'(got_q[1].cyc) - int'(got_q[0].cyc));
            end
        end

        // One-cycle inversion exactly at mid-bit of data bit 3
        got_q.delete(); exp_q.delete();
        off1 = add_frame(8'hFF, 32, 1'b0, 1'b0, 1'b1);
        wave[off1 + 4 * 32 + 16] = 1'b0;
        repeat (40) wave.push_back(1'b1);
        play(base, -1);
        sampled = (MAJ == 1) ? 8'hFF : 8'hF7;
        model(base + off1, sampled, 32, 1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL inv_count: %0d strobes seen, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL inv_strobe[%0d]: got %s, expected %s", i, ev_str(got_q[i]), ev_str(exp_q[i]));
            end
        end
    endtask

    task automatic test_random();
        bit prev_stop = 1'b1;
        got_q.delete(); exp_q.delete();
        for (int k = 0; k < 24; k++) begin
            logic [5:0] pv;
            logic [7:0] d;
            int  peff, gap, off, base;
            bit  pe_b, pt_b, pbit, stop;
            case ($urandom_range(0, 4))
                0:       pv = 6'd8;
                1:       pv = 6'd16;
                2:       pv = 6'd32;
                3:       pv = 6'd12;
                default: pv = 6'd63;
            endcase
            peff = (pv == 6'd16 || pv == 6'd32) ? int'(pv) : 8;
            d    = 8'($urandom);
            pe_b = 1'($urandom_range(0, 1));
            pt_b = 1'($urandom_range(0, 1));
            pbit = good_par(d, pt_b);
            if ($urandom_range(0, 3) == 0) pbit = ~pbit;
            stop = ($urandom_range(0, 5) != 0);
            gap  = prev_stop ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 3));
            repeat (gap) wave.push_back(1'b1);
            off = add_frame(d, peff, pe_b, pbit, stop);
            presc = pv; pen = pe_b; ptyp = pt_b;
            play(base, off + 3 * peff);
            model(base + off, d, int'(pv), pe_b, pt_b, pbit, stop);
            prev_stop = stop;
        end
        idle(60);
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL rand_count: %0d strobes seen, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL rand_strobe[%0d]: got %s, expected %s", i, ev_str(got_q[i]), ev_str(exp_q[i]));
            end
        end
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1; presc = 6'd8; pen = 1'b0; ptyp = 1'b0;
        exp_pdata = 8'h00;
        test_reset();
        test_good_frame();
        test_parity_error();
        test_stop_error();
        test_glitch();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
